wb_stage_regfile: RTL
=====================

// Module: wb_stage_regfile
// PURPOSE
//  Consumer end of the MEM/WB pipeline register: write-back stage plus 32x32 GPR file.
//  - Takes the registered MEM/WB fields and selects the write-back data.
//  - Commits that data to the GPR file and serves the two ID-stage read ports,
//    with internal WB->ID bypass.
//  - Exports the write-back value for forwarding muxes and counts retired instructions.
// PARAMETERS
//  NREG      32   number of GPRs (address width fixed at 5)
//  CNT_W     32   width of retired-instruction counter
//  LINK_OFS  4    added to PCp4 to form link value (PC+8, delay-slot ISA)
// PORTS
//  CLK       in   1   clock, rising edge
//  reset     in   1   synchronous, active-high
//  IR        in   32  instruction in WB (32'h0 = bubble/nop)
//  A3        in   5   destination register
//  AO        in   32  ALU result
//  DR        in   32  load data
//  PCp4      in   32  PC+4 of instruction in WB
//  RegWrite  in   1   GPR write enable
//  MemtoReg  in   1   select DR
//  Link      in   1   select PCp4+LINK_OFS
//  A1, A2    in   5   ID-stage read addresses
//  RD1, RD2  out  32  ID-stage read data (bypassed)
//  WB_WD     out  32  selected write-back data (to forwarding muxes)
//  WB_A3     out  5   effective destination; 0 when no write occurs
//  WB_WE     out  1   RegWrite && (A3 != 0)
//  RetireCnt out  CNT_W  retired non-bubble instructions
// BEHAVIOUR
//  Data select (combinational):
//  - Link=1: WB_WD = PCp4+LINK_OFS (mod 2^32).
//  - else MemtoReg=1: WB_WD = DR.
//  - else: WB_WD = AO.
//  - Link has priority over MemtoReg.
//  Write:
//  - At posedge CLK, when WB_WE=1 and reset=0, GPR[A3] <= WB_WD.
//  - A3=0 never writes; GPR[0] always reads 0.
//  Read (combinational, 0-cycle latency):
//  - RDn = 0 if An==0.
//  - else WB_WD if WB_WE && An==A3 (same-cycle write bypass).
//  - else GPR[An].
//  WB_A3 = WB_WE ? A3 : 0; WB_WE is combinational from inputs.
//  RetireCnt:
//  - Increments by 1 at posedge when IR != 0 and reset=0.
//  - Wraps from 2^CNT_W-1 to 0.
//  - Counts stores and branches too (no GPR write needed).
//  Reset (sync):
//  - All GPRs <= 0 and RetireCnt <= 0.
//  - A write presented in the same cycle as reset is dropped.
//  - Reset mid-stream: next-cycle reads return 0 unless bypassed from the live WB input.
//  Outputs after reset:
//  - RD1/RD2 = 0 unless bypassed.
//  - WB_WD/WB_A3/WB_WE follow inputs (MEM/WB itself is zero after reset, so all 0).
//  Simultaneous read of both ports of the same register as A3: both bypass.
//  X-safety: Link/MemtoReg/RegWrite treated as 0 when IR==0 is NOT assumed; decode owns it.
// STRUCTURE
//  Shared package (mips_pkg):
//  - NOP_IR=32'h0, REG_ZERO=5'd0, LINK_OFS, NREG.
//  Sub-module gpr_file:
//  - Storage, sync reset, 1 write port, 2 async read ports with $0 and bypass logic.
//  Top level: WB data mux, WE qualification, retire counter.
// TESTING
//  1 AO path: A3=5,AO=32'h1234,RegWrite=1 one cycle; then A1=5 -> RD1=32'h1234.
//  2 Load+link priority: MemtoReg=1,Link=1,PCp4=32'h3004 -> WB_WD=32'h3008;
//    MemtoReg=1,Link=0,DR=32'hDEAD -> WB_WD=32'hDEAD.
//  3 $0: A3=0,RegWrite=1,AO=32'hFFFF_FFFF -> WB_WE=0,WB_A3=0; next cycle A1=0 -> RD1=0.
//  4 Bypass: GPR[7]=1; same cycle A3=7,AO=9,WE=1,A1=A2=7 -> RD1=RD2=9.
//  5 Reset mid-stream: 3 writes, then reset with write A3=4 pending -> all GPR 0,
//    GPR[4]=0, RetireCnt=0.
//  6 RetireCnt: IR sequence {nonzero,0,nonzero,nonzero} -> 3;
//    preload 32'hFFFF_FFFF + one retire -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the write-back stage and GPR file.
package mips_pkg;

    localparam logic [31:0] NOP_IR   = 32'h0;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int          LINK_OFS = 4;
    localparam int          NREG     = 32;

endpackage

// File: rtl/gpr_file.sv
// 32-bit general purpose register file: one write port, two combinational
// read ports with hardwired $0 and same-cycle write-to-read bypass.
module gpr_file
    import mips_pkg::*;
#(
    parameter int N = NREG
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] regs_q [N];

    // Storage: reset clears every register and drops any write in that cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != REG_ZERO)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read port 1: $0 reads zero, a live write to the same register wins.
    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == REG_ZERO)               rd1_o = '0;
        else if (we_i && (ra1_i == wa_i))    rd1_o = wd_i;
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == REG_ZERO)               rd2_o = '0;
        else if (we_i && (ra2_i == wa_i))    rd2_o = wd_i;
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects write-back data from the MEM/WB fields, commits
// it to the GPR file, exports it for forwarding and counts retired instructions.
module wb_stage_regfile
    import mips_pkg::*;
#(
    parameter int NREG_P     = NREG,
    parameter int CNT_W      = 32,
    parameter int LINK_OFS_P = LINK_OFS
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic [4:0]       A3,
    input  logic [31:0]      AO,
    input  logic [31:0]      DR,
    input  logic [31:0]      PCp4,
    input  logic             RegWrite,
    input  logic             MemtoReg,
    input  logic             Link,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic [31:0]      WB_WD,
    output logic [4:0]       WB_A3,
    output logic             WB_WE,
    output logic [CNT_W-1:0] RetireCnt
);

    logic [CNT_W-1:0] retire_q, retire_d;

    // Write-back data select: link value beats load data beats ALU result.
    always_comb begin
        WB_WD = AO;
        if (Link)          WB_WD = PCp4 + 32'(LINK_OFS_P);
        else if (MemtoReg) WB_WD = DR;
    end

    // A write to $0 is no write at all, so forwarding sees a clean zero.
    always_comb begin
        WB_WE = RegWrite && (A3 != REG_ZERO);
        WB_A3 = WB_WE ? A3 : REG_ZERO;
    end

    gpr_file #(.N(NREG_P)) u_gpr (
        .CLK   (CLK),
        .reset (reset),
        .we_i  (WB_WE),
        .wa_i  (A3),
        .wd_i  (WB_WD),
        .ra1_i (A1),
        .ra2_i (A2),
        .rd1_o (RD1),
        .rd2_o (RD2)
    );

    // Every non-bubble instruction retires, including stores and branches.
    always_comb begin
        retire_d = retire_q;
        if (IR != NOP_IR) retire_d = retire_q + CNT_W'(1);
    end

    // Retire counter register; wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (reset) retire_q <= '0;
        else       retire_q <= retire_d;
    end

    assign RetireCnt = retire_q;

endmodule
